lb_over_monitor: RTL and testbench

Per-lane overflow monitor for the loopback mux stage. It watches the loopback FIFO overflow strobes and keeps a saturating event count, a sticky per-lane mask and the index of the last lane that overflowed. It packs these into the 32-bit status word that feeds the `lb_over` software register's `user_data_in` on `user_clk`. Software clears and freezes the statistics through a control register bit pair.

---
 rtl/lb_over_pkg.sv | 17 +
 rtl/lb_over_prio_enc.sv | 21 ++
 rtl/lb_over_monitor.sv | 116 +++++++++++
 tb/tb_lb_over_monitor.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/lb_over_pkg.sv
// Shared field layout, saturation limit and FSM state type for the loopback overflow monitor.
package lb_over_pkg;

  localparam int unsigned CNT_LSB  = 16;
  localparam int unsigned CNT_W    = 16;
  localparam int unsigned LAST_LSB = 8;
  localparam int unsigned MASK_W   = 8;

  localparam logic [CNT_W-1:0] CNT_MAX = 16'hFFFF;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    CLR    = 2'd1,
    FROZEN = 2'd2
  } lb_over_state_t;

endpackage

// File: rtl/lb_over_prio_enc.sv
// Lowest-set-bit encoder: index of the lowest asserted request plus an any-set flag.
module lb_over_prio_enc #(
  parameter int unsigned N_LANES = 8
) (
  input  logic [N_LANES-1:0] req,
  output logic [2:0]         idx,
  output logic               any
);

  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int unsigned i = 0; i < N_LANES; i++) begin
      if (req[i] && !any) begin
        idx = 3'(i);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/lb_over_monitor.sv
// Per-lane loopback FIFO overflow monitor: saturating event count, sticky mask, last lane.
// Optional feature macro LB_OVER_TIMESTAMP_EN adds first_over_ts and a free-running cycle counter.
module lb_over_monitor
  import lb_over_pkg::*;
#(
  parameter int unsigned N_LANES = 8
) (
  input  logic               user_clk,
  input  logic               user_rst,
  input  logic               en,
  input  logic [N_LANES-1:0] lane_over,
  input  logic               ctrl_clr,
  input  logic               ctrl_freeze,
`ifdef LB_OVER_TIMESTAMP_EN
  output logic [31:0]        first_over_ts,
`endif
  output logic [31:0]        status_out,
  output logic               over_irq
);

  lb_over_state_t state, state_next;

  logic              clr_q;
  logic              clr_edge;
  logic [CNT_W-1:0]  count_q;
  logic [MASK_W-1:0] mask_q;
  logic [MASK_W-1:0] lane_ext;
  logic              last_valid_q;
  logic [2:0]        last_idx_q;
  logic [2:0]        low_idx;
  logic              low_any;
  logic              count_en;

  lb_over_prio_enc #(
    .N_LANES (N_LANES)
  ) u_prio_enc (
    .req (lane_over),
    .idx (low_idx),
    .any (low_any)
  );

  assign clr_edge = ctrl_clr & ~clr_q;
  assign lane_ext = MASK_W'(lane_over);

  // A freeze sampled on this edge already suppresses the event on the same edge.
  assign count_en = (state == RUN) && en && low_any && !ctrl_freeze;

  always_ff @(posedge user_clk) begin
    if (user_rst) begin
      state <= RUN;
      clr_q <= 1'b0;
    end else begin
      state <= state_next;
      clr_q <= ctrl_clr;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      RUN: begin
        if (clr_edge)         state_next = CLR;
        else if (ctrl_freeze) state_next = FROZEN;
      end
      CLR: begin
        state_next = ctrl_freeze ? FROZEN : RUN;
      end
      FROZEN: begin
        if (clr_edge)          state_next = CLR;
        else if (!ctrl_freeze) state_next = RUN;
      end
      default: state_next = RUN;
    endcase
  end

  always_ff @(posedge user_clk) begin
    if (user_rst || state == CLR) begin
      count_q      <= '0;
      mask_q       <= '0;
      last_valid_q <= 1'b0;
      last_idx_q   <= '0;
      over_irq     <= 1'b0;
    end else if (count_en) begin
      if (count_q != CNT_MAX) count_q <= count_q + 1'b1;
      mask_q       <= mask_q | lane_ext;
      last_valid_q <= 1'b1;
      last_idx_q   <= low_idx;
      over_irq     <= |(mask_q | lane_ext);
    end
  end

  always_comb begin
    status_out = '0;
    status_out[CNT_LSB +: CNT_W]    = count_q;
    status_out[LAST_LSB +: 8]       = {last_valid_q, 4'b0000, last_idx_q};
    status_out[0 +: MASK_W]         = mask_q;
  end

`ifdef LB_OVER_TIMESTAMP_EN
  logic [31:0] ts_cnt;

  always_ff @(posedge user_clk) begin
    if (user_rst) begin
      ts_cnt        <= '0;
      first_over_ts <= '0;
    end else begin
      ts_cnt <= ts_cnt + 1'b1;
      if (state == CLR)
        first_over_ts <= '0;
      else if (count_en && count_q == '0)
        first_over_ts <= ts_cnt;
    end
  end
`endif

endmodule

// File: tb/tb_lb_over_monitor.sv
// Directed self-checking bench for lb_over_monitor with hand-computed status words.
module tb_lb_over_monitor;

  logic        user_clk = 1'b0;
  logic        user_rst;
  logic        en;
  logic [7:0]  lane_over;
  logic        ctrl_clr;
  logic        ctrl_freeze;
  logic [31:0] status_out;
  logic        over_irq;
`ifdef LB_OVER_TIMESTAMP_EN
  logic [31:0] first_over_ts;
`endif

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  lb_over_monitor #(
    .N_LANES (8)
  ) dut (
    .user_clk    (user_clk),
    .user_rst    (user_rst),
    .en          (en),
    .lane_over   (lane_over),
    .ctrl_clr    (ctrl_clr),
    .ctrl_freeze (ctrl_freeze),
`ifdef LB_OVER_TIMESTAMP_EN
    .first_over_ts (first_over_ts),
`endif
    .status_out  (status_out),
    .over_irq    (over_irq)
  );

  always #5 user_clk = ~user_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Advance one edge; inputs set after return take effect on the following edge.
  task automatic step(input int unsigned n = 1);
    repeat (n) begin
      @(posedge user_clk);
      #1;
    end
  endtask

  initial begin
    user_rst = 1'b1; en = 1'b0; lane_over = '0; ctrl_clr = 1'b0; ctrl_freeze = 1'b0;
    step(2);
    chk("rst_status", status_out, 32'h0);
    chk("rst_irq", 32'(over_irq), 32'd0);

    user_rst = 1'b0; en = 1'b1; lane_over = 8'h24;
    step();
    chk("pulse24_status", status_out, 32'h0001_8224);
    chk("pulse24_irq", 32'(over_irq), 32'd1);
    lane_over = 8'h00;
    step(3);
    chk("idle_hold", status_out, 32'h0001_8224);

    en = 1'b0; lane_over = 8'h10;
    step(2);
    chk("en_low_ignored", status_out, 32'h0001_8224);

    // Saturation from a clean start
    user_rst = 1'b1; en = 1'b1; lane_over = 8'h00;
    step();
    chk("rst2_status", status_out, 32'h0);
    user_rst = 1'b0; lane_over = 8'h01;
    step(65534);
    chk("cnt_fffe", status_out, 32'hFFFE_8001);
    step();
    chk("cnt_ffff", status_out, 32'hFFFF_8001);
    step(10);
    chk("cnt_sat", status_out, 32'hFFFF_8001);

    // Clear while lane 7 streams continuously
    lane_over = 8'h80; ctrl_clr = 1'b1;
    step();
    chk("clr_edge_cycle", status_out, 32'hFFFF_8781);
    step();
    chk("clr_zero", status_out, 32'h0);
    chk("clr_irq", 32'(over_irq), 32'd0);
    step();
    chk("clr_resume1", status_out, 32'h0001_8780);
    chk("clr_resume_irq", 32'(over_irq), 32'd1);
    step();
    chk("clr_resume2", status_out, 32'h0002_8780);
    ctrl_clr = 1'b0;

    // Freeze with strobes active
    ctrl_freeze = 1'b1;
    step();
    chk("frz_same_edge", status_out, 32'h0002_8780);
    step(3);
    chk("frz_hold", status_out, 32'h0002_8780);
    lane_over = 8'h03;
    step(2);
    chk("frz_hold_new_lanes", status_out, 32'h0002_8780);
    ctrl_freeze = 1'b0;
    step();
    chk("unfrz_edge", status_out, 32'h0002_8780);
    step();
    chk("unfrz_count", status_out, 32'h0003_8083);

    // Clear and freeze together from RUN
    ctrl_clr = 1'b1; ctrl_freeze = 1'b1;
    step();
    chk("clrfrz_edge", status_out, 32'h0003_8083);
    step();
    chk("clrfrz_zero", status_out, 32'h0);
    step(3);
    chk("clrfrz_held", status_out, 32'h0);
    chk("clrfrz_irq", 32'(over_irq), 32'd0);
    ctrl_clr = 1'b0; ctrl_freeze = 1'b0;
    step();
    chk("clrfrz_release_edge", status_out, 32'h0);
    step();
    chk("clrfrz_resume1", status_out, 32'h0001_8003);
    step();
    chk("clrfrz_resume2", status_out, 32'h0002_8003);

    // Mid-run reset
    user_rst = 1'b1;
    step();
    chk("midrst_status", status_out, 32'h0);
    chk("midrst_irq", 32'(over_irq), 32'd0);

`ifdef LB_OVER_TIMESTAMP_EN
    chk("ts_rst", first_over_ts, 32'd0);
    user_rst = 1'b0; lane_over = 8'h00;
    step(100);
    lane_over = 8'h02;
    step();
    chk("ts_first", first_over_ts, 32'd100);
    lane_over = 8'h00;
    step(5);
    lane_over = 8'h04;
    step();
    chk("ts_later_hold", first_over_ts, 32'd100);
    ctrl_clr = 1'b1;
    step(2);
    chk("ts_clr", first_over_ts, 32'd0);
    ctrl_clr = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
